// File: rtl/exu_wb_arb.sv
// Writeback arbiter: one holding buffer per unit (alu/lsu/mul/div) feeding a registered RF write port.
// Result reaches exu_wb_* one cycle after buffering; a unit is ready when its buffer is empty or granted.
`timescale 1ns/1ps
module exu_wb_arb #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd_addr,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mul_valid,
    output logic            mul_ready,
    input  logic [4:0]      mul_rd_addr,
    input  logic [XLEN-1:0] mul_data,
    input  logic            div_valid,
    output logic            div_ready,
    input  logic [4:0]      div_rd_addr,
    input  logic [XLEN-1:0] div_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd_addr,
    input  logic [XLEN-1:0] lsu_data,
    output logic [4:0]      exu_wb_rd_addr,
    output logic [XLEN-1:0] exu_wb_data,
    output logic            exu_wb_rd_wr_en,
    output logic            exu_alu_busy,
    output logic            exu_mul_busy,
    output logic            exu_div_busy,
    output logic            exu_lsu_busy
);
    localparam int         N     = 4;
    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    // Index doubles as fixed priority: 0 alu, 1 lsu, 2 mul, 3 div
    logic [N-1:0]    w_in_vld;
    logic [4:0]      w_in_rd   [N];
    logic [XLEN-1:0] w_in_data [N];

    assign w_in_vld     = {div_valid, mul_valid, lsu_valid, alu_valid};
    assign w_in_rd[0]   = alu_rd_addr;
    assign w_in_rd[1]   = lsu_rd_addr;
    assign w_in_rd[2]   = mul_rd_addr;
    assign w_in_rd[3]   = div_rd_addr;
    assign w_in_data[0] = alu_data;
    assign w_in_data[1] = lsu_data;
    assign w_in_data[2] = mul_data;
    assign w_in_data[3] = div_data;

    logic [N-1:0]    r_buf_v;
    logic [4:0]      r_buf_rd   [N];
    logic [XLEN-1:0] r_buf_data [N];
    logic [2:0]      r_wait     [N];
    logic [4:0]      r_wb_rd;
    logic [XLEN-1:0] r_wb_data;
    logic            r_wb_en;

    logic [N-1:0] w_urgent;
    logic [N-1:0] w_cand;
    logic [N-1:0] w_grant;
    logic [N-1:0] w_ready;
    logic [N-1:0] w_load;
    logic [1:0]   w_sel;

    always_comb begin
        w_urgent = '0;
        w_load   = '0;
        for (int i = 0; i < N; i++) begin
            w_urgent[i] = r_buf_v[i] && (r_wait[i] >= LIMIT);
            w_load[i]   = w_in_vld[i] && w_ready[i] && (w_in_rd[i] != 5'd0);
        end
    end

    // Urgent class masks the normal class; lowest set bit wins within the class
    assign w_cand  = (|w_urgent) ? w_urgent : r_buf_v;
    assign w_grant = w_cand & (~w_cand + 4'd1);
    assign w_ready = {N{~rst}} & (~r_buf_v | w_grant);

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant[i]) w_sel = 2'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_v <= '0;
            for (int i = 0; i < N; i++) begin
                r_buf_rd[i]   <= '0;
                r_buf_data[i] <= '0;
                r_wait[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w_load[i]) begin
                    r_buf_v[i]    <= 1'b1;
                    r_buf_rd[i]   <= w_in_rd[i];
                    r_buf_data[i] <= w_in_data[i];
                    r_wait[i]     <= '0;
                end else if (w_grant[i] || !r_buf_v[i]) begin
                    r_buf_v[i] <= 1'b0;
                    r_wait[i]  <= '0;
                end else if (r_wait[i] != 3'd7) begin
                    r_wait[i] <= r_wait[i] + 3'd1;
                end
            end
        end
    end

    // Address/data hold their last value when nothing is granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_en   <= 1'b0;
            r_wb_rd   <= '0;
            r_wb_data <= '0;
        end else begin
            r_wb_en <= |r_buf_v;
            if (|r_buf_v) begin
                r_wb_rd   <= r_buf_rd[w_sel];
                r_wb_data <= r_buf_data[w_sel];
            end
        end
    end

    assign alu_ready       = w_ready[0];
    assign lsu_ready       = w_ready[1];
    assign mul_ready       = w_ready[2];
    assign div_ready       = w_ready[3];
    assign exu_alu_busy    = r_buf_v[0];
    assign exu_lsu_busy    = r_buf_v[1];
    assign exu_mul_busy    = r_buf_v[2];
    assign exu_div_busy    = r_buf_v[3];
    assign exu_wb_rd_addr  = r_wb_rd;
    assign exu_wb_data     = r_wb_data;
    assign exu_wb_rd_wr_en = r_wb_en;
endmodule

// File: tb/tb_exu_wb_arb.sv
// Bench for exu_wb_arb: directed scenarios plus random traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_exu_wb_arb;
    localparam int XLEN = 32;
    localparam int SL   = 4;

    logic            clk;
    logic            rst;
    logic [3:0]      t_v;
    logic [4:0]      t_rd   [4];
    logic [XLEN-1:0] t_data [4];
    logic alu_ready, lsu_ready, mul_ready, div_ready;
    logic exu_alu_busy, exu_lsu_busy, exu_mul_busy, exu_div_busy;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            wb_en;
    logic [3:0]      d_rdy;
    logic [3:0]      d_busy;

    // Unit numbering in the bench: 0 alu, 1 lsu, 2 mul, 3 div
    assign d_rdy  = {div_ready, mul_ready, lsu_ready, alu_ready};
    assign d_busy = {exu_div_busy, exu_mul_busy, exu_lsu_busy, exu_alu_busy};

    exu_wb_arb #(.XLEN(XLEN), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(t_v[0]), .alu_ready(alu_ready), .alu_rd_addr(t_rd[0]), .alu_data(t_data[0]),
        .mul_valid(t_v[2]), .mul_ready(mul_ready), .mul_rd_addr(t_rd[2]), .mul_data(t_data[2]),
        .div_valid(t_v[3]), .div_ready(div_ready), .div_rd_addr(t_rd[3]), .div_data(t_data[3]),
        .lsu_valid(t_v[1]), .lsu_ready(lsu_ready), .lsu_rd_addr(t_rd[1]), .lsu_data(t_data[1]),
        .exu_wb_rd_addr(wb_rd), .exu_wb_data(wb_data), .exu_wb_rd_wr_en(wb_en),
        .exu_alu_busy(exu_alu_busy), .exu_mul_busy(exu_mul_busy),
        .exu_div_busy(exu_div_busy), .exu_lsu_busy(exu_lsu_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_t;

    wb_t             exp_q[$];
    bit              m_v    [4];
    logic [4:0]      m_rd   [4];
    logic [XLEN-1:0] m_data [4];
    int              m_age  [4];
    bit              m_acc  [4];
    int              n_chk = 0;
    int              n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Winner = smallest sort key; urgent entries sort ahead of all normal ones
    function automatic int model_winner();
        int best;
        int best_key;
        best     = -1;
        best_key = 1000;
        for (int i = 0; i < 4; i++) begin
            if (m_v[i]) begin
                int key;
                key = (m_age[i] >= SL) ? i : 4 + i;
                if (key < best_key) begin
                    best_key = key;
                    best     = i;
                end
            end
        end
        return best;
    endfunction

    function automatic bit model_ready(input int i);
        return !rst && (!m_v[i] || model_winner() == i);
    endfunction

    function automatic void model_edge();
        int  w;
        bit  rdy [4];
        wb_t e;
        w = model_winner();
        for (int i = 0; i < 4; i++) rdy[i] = model_ready(i);
        if (w >= 0) begin
            e.rd   = m_rd[w];
            e.data = m_data[w];
            exp_q.push_back(e);
        end
        for (int i = 0; i < 4; i++) begin
            m_acc[i] = t_v[i] && rdy[i];
            if (i == w) m_v[i] = 0;
            else if (m_v[i]) m_age[i] = (m_age[i] + 1 > 7) ? 7 : m_age[i] + 1;
            if (m_acc[i] && t_rd[i] != 5'd0) begin
                m_v[i]    = 1;
                m_rd[i]   = t_rd[i];
                m_data[i] = t_data[i];
                m_age[i]  = 0;
            end
            if (!m_v[i]) m_age[i] = 0;
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 4; i++) begin
            m_v[i]   = 0;
            m_age[i] = 0;
            m_acc[i] = 0;
        end
        exp_q.delete();
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (!rst) model_edge();
    endtask

    task automatic drive(input int u, input logic [4:0] rd, input logic [XLEN-1:0] d);
        t_v[u]    = 1'b1;
        t_rd[u]   = rd;
        t_data[u] = d;
    endtask

    // Monitor: compares ready/busy every cycle and pops the scoreboard on each writeback pulse
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                for (int i = 0; i < 4; i++) begin
                    chk($sformatf("ready[%0d]", i), 64'(d_rdy[i]), 64'(model_ready(i)));
                    chk($sformatf("busy[%0d]", i), 64'(d_busy[i]), 64'(m_v[i]));
                end
                if (wb_en === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL wb_unexpected: got pulse rd %0d, expected no writeback", wb_rd);
                    end else begin
                        wb_t e;
                        e = exp_q.pop_front();
                        chk("wb_rd", 64'(wb_rd), 64'(e.rd));
                        chk("wb_data", 64'(wb_data), 64'(e.data));
                    end
                end
            end
        end
    end

    initial begin
        int alu_n;
        rst = 1'b1;
        t_v = '0;
        for (int i = 0; i < 4; i++) begin
            t_rd[i]   = '0;
            t_data[i] = '0;
        end
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_en", 64'(wb_en), 64'd0);
        chk("rst_wb_rd", 64'(wb_rd), 64'd0);
        chk("rst_wb_data", 64'(wb_data), 64'd0);
        chk("rst_ready", 64'(d_rdy), 64'd0);
        chk("rst_busy", 64'(d_busy), 64'd0);
        rst = 1'b0;
        step();

        // Single mul result
        drive(2, 5'd5, 32'h1234);
        step();
        t_v = '0;
        chk("single_busy_on", 64'(exu_mul_busy), 64'd1);
        chk("single_early", 64'(wb_en), 64'd0);
        step();
        chk("single_en", 64'(wb_en), 64'd1);
        chk("single_rd", 64'(wb_rd), 64'd5);
        chk("single_data", 64'(wb_data), 64'h1234);
        chk("single_busy_off", 64'(exu_mul_busy), 64'd0);
        step();
        chk("single_pulse_end", 64'(wb_en), 64'd0);

        // Simultaneous arrival on all four units
        drive(0, 5'd1, 32'hA1);
        drive(1, 5'd2, 32'hA2);
        drive(2, 5'd3, 32'hA3);
        drive(3, 5'd4, 32'hA4);
        step();
        t_v = '0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("simul_en%0d", k), 64'(wb_en), 64'd1);
            chk($sformatf("simul_rd%0d", k), 64'(wb_rd), 64'(k + 1));
            chk($sformatf("simul_busy%0d", k), 64'(d_busy), 64'(4'(4'hF << (k + 1))));
        end
        step();
        chk("simul_idle", 64'(wb_en), 64'd0);

        // x0 destination is dropped at acceptance
        chk("x0_ready_before", 64'(lsu_ready), 64'd1);
        drive(1, 5'd0, 32'hFFFF_FFFF);
        step();
        t_v = '0;
        chk("x0_busy", 64'(exu_lsu_busy), 64'd0);
        chk("x0_ready_after", 64'(lsu_ready), 64'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("x0_no_wb%0d", k), 64'(wb_en), 64'd0);
        end

        // Same-edge replace on the lsu buffer
        drive(1, 5'd7, 32'hBEEF_0007);
        step();
        drive(1, 5'd8, 32'hBEEF_0008);
        chk("replace_ready", 64'(lsu_ready), 64'd1);
        step();
        t_v = '0;
        chk("replace_first_rd", 64'(wb_rd), 64'd7);
        chk("replace_busy", 64'(exu_lsu_busy), 64'd1);
        step();
        chk("replace_second_en", 64'(wb_en), 64'd1);
        chk("replace_second_rd", 64'(wb_rd), 64'd8);
        step();
        chk("replace_idle", 64'(wb_en), 64'd0);

        // Starvation: div buffered behind a continuous alu stream
        alu_n = 0;
        drive(0, 5'd10, 32'd100);
        drive(3, 5'd20, 32'hD1D0);
        step();
        t_v[3] = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (m_acc[0]) begin
                alu_n++;
                t_rd[0]   = 5'(10 + alu_n % 10);
                t_data[0] = 32'(100 + alu_n);
            end
            chk($sformatf("starve_alu_ready_c%0d", c), 64'(alu_ready), (c == 5) ? 64'd0 : 64'd1);
            step();
            if (c == 5) begin
                chk("starve_div_rd", 64'(wb_rd), 64'd20);
                chk("starve_div_data", 64'(wb_data), 64'hD1D0);
            end
        end
        t_v = '0;
        repeat (3) step();

        // Asynchronous reset with three buffers occupied
        drive(1, 5'd11, 32'h11);
        drive(2, 5'd12, 32'h12);
        drive(3, 5'd13, 32'h13);
        step();
        t_v = '0;
        step();
        chk("pre_rst_en", 64'(wb_en), 64'd1);
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        chk("arst_wb_en", 64'(wb_en), 64'd0);
        chk("arst_wb_rd", 64'(wb_rd), 64'd0);
        chk("arst_wb_data", 64'(wb_data), 64'd0);
        chk("arst_ready", 64'(d_rdy), 64'd0);
        chk("arst_busy", 64'(d_busy), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(d_rdy), 64'hF);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("post_rst_no_wb%0d", k), 64'(wb_en), 64'd0);
        end

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                t_v[i]    = ($urandom_range(0, 99) < 45);
                t_rd[i]   = 5'($urandom_range(0, 31));
                t_data[i] = $urandom;
            end
            step();
        end
        t_v = '0;
        repeat (12) step();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
